// File: rtl/quad_pkg.sv
// Shared types and step decoding for the quadrature decoder.
package quad_pkg;

  localparam int unsigned FILT_LEN_MAX = 15;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILL
  } step_t;

  function automatic phase_t next_fwd(phase_t ph);
    case (ph)
      PH_00:   next_fwd = PH_01;
      PH_01:   next_fwd = PH_11;
      PH_11:   next_fwd = PH_10;
      default: next_fwd = PH_00;
    endcase
  endfunction

  function automatic step_t decode_step(phase_t old_ph, phase_t new_ph);
    if (old_ph == new_ph) begin
      decode_step = STEP_NONE;
    end else if ((old_ph ^ new_ph) == 2'b11) begin
      decode_step = STEP_ILL;
    end else if (new_ph == next_fwd(old_ph)) begin
      decode_step = STEP_FWD;
    end else begin
      decode_step = STEP_REV;
    end
  endfunction

endpackage

// File: rtl/quad_in_filter.sv
// 2-FF synchroniser followed by a run-length de-glitch filter for one phase input.
module quad_in_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILT_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned RunW = $clog2(FILT_LEN_MAX + 1);

  logic            sync1_q, sync2_q;
  logic            filt_q, filt_d;
  logic [RunW-1:0] run_q, run_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      run_q   <= run_d;
    end
  end

  // Run counter holds the number of consecutive differing samples already seen.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == RunW'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/quad_dec_counter.sv
// Quadrature decoder: filtered phase tracking, inc/dec/err pulses and a wrapping position count.
module quad_dec_counter
  import quad_pkg::*;
#(
  parameter int unsigned FILT_LEN = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr,
  output logic             inc,
  output logic             dec,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic {StAcq, StTrack} state_e;

  // Acquire lasts until a level held through reset has crossed synchroniser and filter.
  localparam int unsigned AcqCycles = FILT_LEN + 3;
  localparam int unsigned AcqW      = 5;

  logic             filt_a, filt_b;
  phase_t           ph_new, phase_q, phase_d;
  state_e           state_q, state_d;
  logic [AcqW-1:0]  acq_q, acq_d;
  step_t            step;
  logic             inc_q, inc_d, dec_q, dec_d, err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  quad_in_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (qa),
    .dout (filt_a)
  );

  quad_in_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (qb),
    .dout (filt_b)
  );

  assign ph_new = phase_t'({filt_a, filt_b});
  assign step   = decode_step(phase_q, ph_new);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StAcq;
      acq_q    <= '0;
      phase_q  <= PH_00;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acq_q    <= acq_d;
      phase_q  <= phase_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    phase_d = ph_new;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StAcq: begin
        if (acq_q == AcqW'(AcqCycles - 1)) begin
          state_d = StTrack;
        end else begin
          acq_d = acq_q + 1'b1;
        end
      end
      StTrack: begin
        inc_d = (step == STEP_FWD);
        dec_d = (step == STEP_REV);
        err_d = (step == STEP_ILL);
      end
    endcase

    sticky_d = sticky_q | err_d;
    cnt_d    = cnt_q;
    if (inc_q) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_q) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
  end

  assign inc        = inc_q;
  assign dec        = dec_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign cnt        = cnt_q;

endmodule

// File: tb/tb_quad_dec_counter.sv
// Self-checking bench for quad_dec_counter: directed scenarios plus a random walk against a position model.
module tb_quad_dec_counter;

  localparam int unsigned FiltLen = 2;
  localparam int unsigned CntW    = 8;

  logic            clk = 1'b0;
  logic            rst, qa, qb, clr;
  logic            inc, dec, err, err_sticky;
  logic [CntW-1:0] cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int n_inc    = 0;
  int n_dec    = 0;
  int n_err    = 0;
  int n_bad    = 0;
  int n_x      = 0;

  // Model: position on the 4-state cycle and the expected wrapped count.
  int ref_pos;
  int ref_cnt;
  logic [1:0] ph_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_dec_counter #(.FILT_LEN(FiltLen), .CNT_W(CntW)) dut (
    .clk        (clk),
    .rst        (rst),
    .qa         (qa),
    .qb         (qb),
    .clr        (clr),
    .inc        (inc),
    .dec        (dec),
    .err        (err),
    .err_sticky (err_sticky),
    .cnt        (cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      n_inc += int'(inc);
      n_dec += int'(dec);
      n_err += int'(err);
      if ((inc && dec) || ((inc || dec) && err)) n_bad++;
      if ($isunknown(cnt)) n_x++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int dir, input int hold);
    @(negedge clk);
    ref_pos = (ref_pos + dir + 4) % 4;
    ref_cnt = (ref_cnt + dir + 256) % 256;
    {qa, qb} = ph_tab[ref_pos];
    repeat (hold) @(posedge clk);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  int lat, hits, decs, found, dir;
  int b_inc, b_dec, b_err, e_inc, e_dec;

  initial begin
    rst = 1'b1; qa = 1'b0; qb = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt", cnt, 0);
    check("rst_inc", inc, 0);
    check("rst_dec", dec, 0);
    check("rst_err", err, 0);
    check("rst_sticky", err_sticky, 0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    ref_pos = 0;
    ref_cnt = 0;

    // Forward sequence with latency measured from the capturing edge.
    for (int s = 0; s < 4; s++) begin
      lat = -1; hits = 0; decs = 0;
      @(negedge clk);
      ref_pos = (ref_pos + 1) % 4;
      {qa, qb} = ph_tab[ref_pos];
      @(posedge clk);
      for (int j = 1; j <= 7; j++) begin
        @(posedge clk);
        #1;
        if (inc) begin
          hits++;
          if (lat < 0) lat = j;
        end
        if (dec) decs++;
      end
      ref_cnt++;
      check("fwd_latency", lat, 4);
      check("fwd_one_inc", hits, 1);
      check("fwd_no_dec", decs, 0);
    end
    check("fwd_cnt", cnt, ref_cnt);

    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    ref_cnt = 0;
    check("clr_cnt", cnt, 0);

    // Wrap in both directions.
    b_inc = n_inc;
    repeat (255) step(1, 4);
    settle();
    check("wrap_ff", cnt, 8'hFF);
    check("wrap_inc_cnt", n_inc - b_inc, 255);
    step(1, 4);
    settle();
    check("wrap_00", cnt, 8'h00);
    step(-1, 4);
    settle();
    check("wrap_back_ff", cnt, 8'hFF);
    check("wrap_model", cnt, ref_cnt);

    // Random walk at or above the throughput limit.
    b_inc = n_inc; b_dec = n_dec; e_inc = 0; e_dec = 0;
    for (int i = 0; i < 150; i++) begin
      dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
      if (dir > 0) e_inc++; else e_dec++;
      step(dir, $urandom_range(3, 6));
      if (i % 50 == 49) begin
        settle();
        check("rand_cnt_mid", cnt, ref_cnt);
      end
    end
    settle();
    check("rand_cnt", cnt, ref_cnt);
    check("rand_incs", n_inc - b_inc, e_inc);
    check("rand_decs", n_dec - b_dec, e_dec);

    // Single-cycle glitch on qb at phase 00.
    while (ref_pos != 0) step(1, 4);
    settle();
    b_inc = n_inc; b_dec = n_dec; b_err = n_err;
    @(negedge clk) qb = 1'b1;
    @(negedge clk) qb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_inc", n_inc - b_inc, 0);
    check("glitch_dec", n_dec - b_dec, 0);
    check("glitch_err", n_err - b_err, 0);
    check("glitch_cnt", cnt, ref_cnt);

    // Illegal 00 -> 11 jump, then clr.
    b_inc = n_inc; b_dec = n_dec; b_err = n_err;
    @(negedge clk);
    qa = 1'b1; qb = 1'b1;
    ref_pos = 2;
    repeat (8) @(posedge clk);
    #1;
    check("ill_err_pulses", n_err - b_err, 1);
    check("ill_no_steps", (n_inc - b_inc) + (n_dec - b_dec), 0);
    check("ill_sticky", err_sticky, 1);
    check("ill_cnt", cnt, ref_cnt);
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1;
    check("ill_clr_cnt", cnt, 0);
    check("ill_clr_sticky", err_sticky, 0);
    @(negedge clk) clr = 1'b0;
    ref_cnt = 0;

    // clr in the same cycle as an inc pulse.
    repeat (5) step(1, 4);
    settle();
    check("pri_cnt5", cnt, 8'h05);
    @(negedge clk);
    ref_pos = (ref_pos + 1) % 4;
    {qa, qb} = ph_tab[ref_pos];
    found = 0;
    for (int j = 0; j < 12 && found == 0; j++) begin
      @(posedge clk);
      #1;
      if (inc) found = 1;
    end
    check("pri_inc_seen", found, 1);
    clr = 1'b1;
    check("pri_inc_with_clr", inc, 1);
    check("pri_cnt_before", cnt, 8'h05);
    @(posedge clk);
    #1;
    check("pri_cnt_cleared", cnt, 0);
    clr = 1'b0;
    ref_cnt = 0;

    // Reset in the middle of stepping, then acquire with inputs held at 11.
    repeat (2) step(1, 4);
    settle();
    check("mid_cnt", cnt, ref_cnt);
    @(negedge clk);
    ref_pos = (ref_pos + 1) % 4;
    {qa, qb} = ph_tab[ref_pos];
    #3 rst = 1'b1;
    #1;
    check("mid_rst_cnt", cnt, 0);
    check("mid_rst_outs", {inc, dec, err, err_sticky}, 4'b0000);
    qa = 1'b1; qb = 1'b1;
    repeat (3) @(posedge clk);
    b_inc = n_inc; b_dec = n_dec; b_err = n_err;
    @(negedge clk) rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("acq_no_pulse", (n_inc - b_inc) + (n_dec - b_dec) + (n_err - b_err), 0);
    check("acq_cnt", cnt, 0);
    @(negedge clk) qb = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("acq_one_inc", n_inc - b_inc, 1);
    check("acq_no_dec_err", (n_dec - b_dec) + (n_err - b_err), 0);
    check("acq_cnt1", cnt, 1);

    check("exclusive_pulses", n_bad, 0);
    check("cnt_known", n_x, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
